// File: rtl/alu_seq_pkg.sv
// Shared constants for the ALU sequencer: opcodes, FSM state encoding and
// bit positions of the one-hot operation-select vector.
package alu_seq_pkg;

   localparam int N_OPS = 13;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_MUL = 4'd2;
   localparam logic [3:0] OP_DIV = 4'd3;
   localparam logic [3:0] OP_MOD = 4'd4;
   localparam logic [3:0] OP_CMP = 4'd5;
   localparam logic [3:0] OP_AND = 4'd6;
   localparam logic [3:0] OP_OR  = 4'd7;
   localparam logic [3:0] OP_NOT = 4'd8;
   localparam logic [3:0] OP_MOV = 4'd9;
   localparam logic [3:0] OP_LSL = 4'd10;
   localparam logic [3:0] OP_LSR = 4'd11;
   localparam logic [3:0] OP_ASR = 4'd12;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_EXEC = 2'd2;
   localparam logic [1:0] S_WB   = 2'd3;

   // Strobe bit index equals the opcode value, so decode is a plain shift.
   localparam int B_ADD = 0;
   localparam int B_SUB = 1;
   localparam int B_MUL = 2;
   localparam int B_DIV = 3;
   localparam int B_MOD = 4;
   localparam int B_CMP = 5;
   localparam int B_AND = 6;
   localparam int B_OR  = 7;
   localparam int B_NOT = 8;
   localparam int B_MOV = 9;
   localparam int B_LSL = 10;
   localparam int B_LSR = 11;
   localparam int B_ASR = 12;

   typedef logic [N_OPS-1:0] op_vec_t;

endpackage

// File: rtl/op_decode.sv
// Combinational opcode decoder: one-hot operation select plus class flags.
module op_decode
   import alu_seq_pkg::*;
(
   input  logic [3:0] opcode,
   output op_vec_t    strobes,
   output logic       is_cmp,
   output logic       is_divmod,
   output logic       illegal
);

   assign illegal   = (opcode > OP_ASR);
   assign strobes   = illegal ? '0 : (op_vec_t'(1) << opcode);
   assign is_cmp    = (opcode == OP_CMP);
   assign is_divmod = (opcode == OP_DIV) || (opcode == OP_MOD);

endmodule

// File: rtl/alu_sequencer.sv
// Four-state control stage in front of the ALU: fetch operands from the
// register file, strobe the ALU, then write back the result or the flags.
module alu_sequencer
   import alu_seq_pkg::*;
#(
   parameter int W  = 32,
   parameter int RA = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          inst_valid,
   output logic          inst_ready,
   input  logic [3:0]    opcode,
   input  logic [RA-1:0] rd,
   input  logic [RA-1:0] rs1,
   input  logic [RA-1:0] rs2,
   input  logic          use_imm,
   input  logic [15:0]   imm,
   output logic [RA-1:0] rf_ra1,
   output logic [RA-1:0] rf_ra2,
   input  logic [W-1:0]  rf_rd1,
   input  logic [W-1:0]  rf_rd2,
   output logic          rf_we,
   output logic [RA-1:0] rf_wa,
   output logic [W-1:0]  rf_wd,
   output logic [W-1:0]  AIn,
   output logic [W-1:0]  BIn,
   output logic          ldA,
   output logic          ldB,
   output logic          clrA,
   output logic          clrB,
   output logic          ldResult,
   output logic          clrResult,
   output logic          isAdd,
   output logic          isSub,
   output logic          isMul,
   output logic          isDiv,
   output logic          isMod,
   output logic          isCmp,
   output logic          isAnd,
   output logic          isOr,
   output logic          isNot,
   output logic          isMov,
   output logic          isLsl,
   output logic          isLsr,
   output logic          isAsr,
   input  logic [W-1:0]  aluResult,
   output logic          flag_wr,
   output logic          done,
   output logic          err
);

   logic [1:0]    state;
   logic          started_q;
   logic          clr_q;
   logic          ill_err_q;
   logic [3:0]    op_q;
   logic [RA-1:0] rd_q, rs1_q, rs2_q;
   logic          use_imm_q;
   logic [15:0]   imm_q;
   logic [W-1:0]  b_q;

   logic [3:0]    dec_opcode;
   op_vec_t       strobes;
   op_vec_t       op_vec;
   logic          is_cmp, is_divmod, illegal;
   logic          accept, div_zero;
   logic [W-1:0]  b_mux;

   // In IDLE the decoder classifies the incoming opcode; afterwards the held one.
   assign dec_opcode = (state == S_IDLE) ? opcode : op_q;

   op_decode u_op_decode (
      .opcode    (dec_opcode),
      .strobes   (strobes),
      .is_cmp    (is_cmp),
      .is_divmod (is_divmod),
      .illegal   (illegal)
   );

   assign inst_ready = started_q && (state == S_IDLE);
   assign accept     = inst_valid && inst_ready;
   assign b_mux      = use_imm_q ? {{(W-16){imm_q[15]}}, imm_q} : rf_rd2;
   assign div_zero   = is_divmod && (b_q == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: the captured fields are reset too, so an instruction cut off by
      // reset leaves nothing behind that a later cycle could act on.
      if (!rst_n) begin
         state     <= S_IDLE;
         started_q <= 1'b0;
         clr_q     <= 1'b0;
         ill_err_q <= 1'b0;
         op_q      <= '0;
         rd_q      <= '0;
         rs1_q     <= '0;
         rs2_q     <= '0;
         use_imm_q <= 1'b0;
         imm_q     <= '0;
         b_q       <= '0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values.
         started_q <= 1'b1;
         clr_q     <= !started_q;
         ill_err_q <= accept && illegal;
         case (state)
            S_IDLE: if (accept && !illegal) begin
               op_q      <= opcode;
               rd_q      <= rd;
               rs1_q     <= rs1;
               rs2_q     <= rs2;
               use_imm_q <= use_imm;
               imm_q     <= imm;
               state     <= S_LOAD;
            end
            S_LOAD: begin
               b_q   <= b_mux;
               state <= S_EXEC;
            end
            S_EXEC:  state <= div_zero ? S_IDLE : S_WB;
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      // NOTE: every output gets a default first so no path infers a latch.
      rf_ra1   = '0;
      rf_ra2   = '0;
      AIn      = '0;
      BIn      = '0;
      ldA      = 1'b0;
      ldB      = 1'b0;
      ldResult = 1'b0;
      flag_wr  = 1'b0;
      rf_we    = 1'b0;
      rf_wa    = '0;
      rf_wd    = '0;
      done     = 1'b0;
      op_vec   = '0;
      case (state)
         S_LOAD: begin
            rf_ra1 = rs1_q;
            rf_ra2 = rs2_q;
            AIn    = rf_rd1;
            BIn    = b_mux;
            ldA    = 1'b1;
            ldB    = 1'b1;
         end
         S_EXEC: begin
            op_vec   = strobes;
            flag_wr  = is_cmp;
            ldResult = !is_cmp && !div_zero;
         end
         S_WB: begin
            rf_we = !is_cmp;
            rf_wa = is_cmp ? '0 : rd_q;
            rf_wd = is_cmp ? '0 : aluResult;
            done  = 1'b1;
         end
         default: ;
      endcase
   end

   assign err       = ill_err_q || ((state == S_EXEC) && div_zero);
   assign clrA      = clr_q;
   assign clrB      = clr_q;
   assign clrResult = clr_q;

   assign isAdd = op_vec[B_ADD];
   assign isSub = op_vec[B_SUB];
   assign isMul = op_vec[B_MUL];
   assign isDiv = op_vec[B_DIV];
   assign isMod = op_vec[B_MOD];
   assign isCmp = op_vec[B_CMP];
   assign isAnd = op_vec[B_AND];
   assign isOr  = op_vec[B_OR];
   assign isNot = op_vec[B_NOT];
   assign isMov = op_vec[B_MOV];
   assign isLsl = op_vec[B_LSL];
   assign isLsr = op_vec[B_LSR];
   assign isAsr = op_vec[B_ASR];

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small register file and ALU around it.
module tb_alu_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        inst_valid = 1'b0;
   logic        inst_ready;
   logic [3:0]  opcode = '0;
   logic [3:0]  rd = '0, rs1 = '0, rs2 = '0;
   logic        use_imm = 1'b0;
   logic [15:0] imm = '0;
   logic [3:0]  rf_ra1, rf_ra2, rf_wa;
   logic [31:0] rf_rd1, rf_rd2, rf_wd, AIn, BIn, aluResult;
   logic        rf_we, ldA, ldB, clrA, clrB, ldResult, clrResult;
   logic        isAdd, isSub, isMul, isDiv, isMod, isCmp, isAnd, isOr;
   logic        isNot, isMov, isLsl, isLsr, isAsr, flag_wr, done, err;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] regs [16];
   logic [31:0] a_r = '0, b_r = '0;

   always #5 clk = ~clk;

   alu_sequencer #(.W(32), .RA(4)) dut (
      .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .inst_ready(inst_ready),
      .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .use_imm(use_imm), .imm(imm),
      .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
      .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .AIn(AIn), .BIn(BIn),
      .ldA(ldA), .ldB(ldB), .clrA(clrA), .clrB(clrB), .ldResult(ldResult),
      .clrResult(clrResult), .isAdd(isAdd), .isSub(isSub), .isMul(isMul),
      .isDiv(isDiv), .isMod(isMod), .isCmp(isCmp), .isAnd(isAnd), .isOr(isOr),
      .isNot(isNot), .isMov(isMov), .isLsl(isLsl), .isLsr(isLsr), .isAsr(isAsr),
      .aluResult(aluResult), .flag_wr(flag_wr), .done(done), .err(err)
   );

   wire [12:0] ops = {isAsr, isLsr, isLsl, isMov, isNot, isOr, isAnd,
                      isCmp, isMod, isDiv, isMul, isSub, isAdd};
   wire any_out = |{inst_ready, rf_ra1, rf_ra2, rf_we, rf_wa, rf_wd, AIn, BIn,
                    ldA, ldB, clrA, clrB, ldResult, clrResult, ops, flag_wr, done, err};

   // Register file and ALU fixtures surrounding the sequencer
   assign rf_rd1 = regs[rf_ra1];
   assign rf_rd2 = regs[rf_ra2];

   always @(posedge clk) begin
      if (rf_we) regs[rf_wa] <= rf_wd;
      if (ldA) a_r <= AIn;
      if (ldB) b_r <= BIn;
      if (ldResult) begin
         if (isAdd)      aluResult <= a_r + b_r;
         else if (isSub) aluResult <= a_r - b_r;
         else if (isMul) aluResult <= a_r * b_r;
         else if (isAnd) aluResult <= a_r & b_r;
         else if (isOr)  aluResult <= a_r | b_r;
         else if (isMov) aluResult <= b_r;
         else            aluResult <= 32'd0;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         n_tests++;
         if (!$onehot0(ops)) begin
            n_fail++;
            $display("FAIL onehot_strobes: ops=%b required at most one bit", ops);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic issue(input logic [3:0] op, input logic [3:0] d, input logic [3:0] s1,
                        input logic [3:0] s2, input logic ui, input logic [15:0] im);
      int waited;
      waited = 0;
      @(negedge clk);
      while (!inst_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      n_tests++;
      if (inst_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL issue_ready: inst_ready=%b required 1", inst_ready);
      end
      opcode = op; rd = d; rs1 = s1; rs2 = s2; use_imm = ui; imm = im;
      inst_valid = 1'b1;
      @(posedge clk);
      #1 inst_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      n_tests++;
      if (any_out !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: any_out=%b required 0", any_out);
      end
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);
      n_tests++;
      if ({clrA, clrB, clrResult, inst_ready} !== 4'b1111) begin
         n_fail++;
         $display("FAIL reset_clr_pulse: clr/ready=%b required 1111", {clrA, clrB, clrResult, inst_ready});
      end
      @(negedge clk);
      n_tests++;
      if ({clrA, clrB, clrResult, inst_ready} !== 4'b0001) begin
         n_fail++;
         $display("FAIL reset_clr_once: clr/ready=%b required 0001", {clrA, clrB, clrResult, inst_ready});
      end
   endtask

   task automatic test_add();
      issue(4'd0, 4'd3, 4'd1, 4'd2, 1'b0, 16'h0);
      @(negedge clk);
      n_tests++;
      if ({ldA, ldB, inst_ready, rf_ra1, rf_ra2, AIn, BIn, ops} !==
          {1'b1, 1'b1, 1'b0, 4'd1, 4'd2, 32'd5, 32'd7, 13'b0}) begin
         n_fail++;
         $display("FAIL add_load: ld=%b%b ready=%b ra=%0d,%0d A=%0d B=%0d required 11 0 1,2 5 7",
                  ldA, ldB, inst_ready, rf_ra1, rf_ra2, AIn, BIn);
      end
      @(negedge clk);
      n_tests++;
      if ({ops, ldResult, ldA, rf_we, done} !== {13'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL add_exec: ops=%b ldResult=%b required 0000000000001 1", ops, ldResult);
      end
      @(negedge clk);
      n_tests++;
      if ({rf_we, rf_wa, rf_wd, done, ops, ldResult} !== {1'b1, 4'd3, 32'd12, 1'b1, 13'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL add_wb: we=%b wa=%0d wd=%0d done=%b required 1 3 12 1", rf_we, rf_wa, rf_wd, done);
      end
      @(negedge clk);
      n_tests++;
      if ({regs[3], inst_ready, done} !== {32'd12, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL add_retire: r3=%0d ready=%b done=%b required 12 1 0", regs[3], inst_ready, done);
      end
   endtask

   task automatic test_imm_sub();
      issue(4'd1, 4'd7, 4'd4, 4'd0, 1'b1, 16'hFFFF);
      @(negedge clk);
      n_tests++;
      if ({AIn, BIn} !== {32'd10, 32'hFFFF_FFFF}) begin
         n_fail++;
         $display("FAIL imm_operands: A=%h B=%h required 0000000a ffffffff", AIn, BIn);
      end
      @(negedge clk);
      n_tests++;
      if ({ops, ldResult} !== {13'b10, 1'b1}) begin
         n_fail++;
         $display("FAIL imm_exec: ops=%b ldResult=%b required 0000000000010 1", ops, ldResult);
      end
      @(negedge clk);
      n_tests++;
      if ({rf_we, rf_wa, rf_wd, done} !== {1'b1, 4'd7, 32'd11, 1'b1}) begin
         n_fail++;
         $display("FAIL imm_wb: we=%b wa=%0d wd=%0d done=%b required 1 7 11 1", rf_we, rf_wa, rf_wd, done);
      end
   endtask

   task automatic test_cmp();
      logic saw_we;
      issue(4'd5, 4'd9, 4'd5, 4'd6, 1'b0, 16'h0);
      @(negedge clk);
      saw_we = rf_we;
      @(negedge clk);
      saw_we |= rf_we;
      n_tests++;
      if ({ops, flag_wr, ldResult} !== {13'b100000, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL cmp_exec: ops=%b flag_wr=%b ldResult=%b required 0000000100000 1 0", ops, flag_wr, ldResult);
      end
      @(negedge clk);
      saw_we |= rf_we;
      n_tests++;
      if ({saw_we, done, flag_wr} !== 3'b010) begin
         n_fail++;
         $display("FAIL cmp_wb: rf_we_seen=%b done=%b flag_wr=%b required 0 1 0", saw_we, done, flag_wr);
      end
   endtask

   task automatic test_div_zero();
      issue(4'd3, 4'd10, 4'd8, 4'd9, 1'b0, 16'h0);
      @(negedge clk);
      @(negedge clk);
      n_tests++;
      if ({err, isDiv, ldResult, rf_we} !== 4'b1100) begin
         n_fail++;
         $display("FAIL div0_exec: err=%b isDiv=%b ldResult=%b rf_we=%b required 1 1 0 0", err, isDiv, ldResult, rf_we);
      end
      @(negedge clk);
      n_tests++;
      if ({err, rf_we, done, inst_ready, regs[10]} !== {4'b0001, 32'hA5A5}) begin
         n_fail++;
         $display("FAIL div0_after: err=%b we=%b done=%b ready=%b r10=%h required 0 0 0 1 a5a5",
                  err, rf_we, done, inst_ready, regs[10]);
      end
   endtask

   task automatic test_illegal();
      issue(4'd14, 4'd1, 4'd1, 4'd2, 1'b0, 16'h0);
      @(negedge clk);
      n_tests++;
      if ({err, inst_ready, ldA, ldB, ops} !== {4'b1100, 13'b0}) begin
         n_fail++;
         $display("FAIL illegal_err: err=%b ready=%b ld=%b%b ops=%b required 1 1 00 0", err, inst_ready, ldA, ldB, ops);
      end
      @(negedge clk);
      n_tests++;
      if ({err, inst_ready, ldA, ops} !== {3'b010, 13'b0}) begin
         n_fail++;
         $display("FAIL illegal_idle: err=%b ready=%b ldA=%b required 0 1 0", err, inst_ready, ldA);
      end
   endtask

   task automatic test_back_to_back();
      int n_done, first, last;
      logic gap_ok, wd_ok;
      issue(4'd0, 4'd13, 4'd1, 4'd2, 1'b0, 16'h0);
      @(negedge clk);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      n_tests++;
      if (any_out !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset_outputs: any_out=%b required 0", any_out);
      end
      @(negedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);
      n_tests++;
      if ({clrA, clrB, clrResult, inst_ready, regs[13]} !== {4'b1111, 32'hDEAD}) begin
         n_fail++;
         $display("FAIL mid_reset_recover: clr/ready=%b r13=%h required 1111 dead",
                  {clrA, clrB, clrResult, inst_ready}, regs[13]);
      end
      opcode = 4'd0; rd = 4'd14; rs1 = 4'd1; rs2 = 4'd2; use_imm = 1'b0;
      inst_valid = 1'b1;
      n_done = 0; first = -1; last = -1; gap_ok = 1'b1; wd_ok = 1'b1;
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         if (done) begin
            if (first < 0) first = i;
            if (last >= 0 && i - last != 4) gap_ok = 1'b0;
            if (rf_wd !== 32'd12 || rf_wa !== 4'd14) wd_ok = 1'b0;
            last = i;
            n_done++;
         end
      end
      inst_valid = 1'b0;
      n_tests++;
      if ({first, n_done, gap_ok, wd_ok} !== {32'd2, 32'd4, 1'b1, 1'b1}) begin
         n_fail++;
         $display("FAIL back_to_back: first=%0d count=%0d gap_ok=%b wd_ok=%b required 2 4 1 1",
                  first, n_done, gap_ok, wd_ok);
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) regs[i] = '0;
      regs[1] = 32'd5;   regs[2] = 32'd7;
      regs[4] = 32'd10;
      regs[5] = 32'd9;   regs[6] = 32'd4;
      regs[8] = 32'd100; regs[9] = 32'd0;  regs[10] = 32'hA5A5;
      regs[13] = 32'hDEAD;
      test_reset();
      test_add();
      test_imm_sub();
      test_cmp();
      test_div_zero();
      test_illegal();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
